iob_plic_ctrl: RTL and testbench

- Platform-level interrupt controller on the IOb native slave bus.
- Collects N_SOURCES interrupt lines through per-source gateways, then arbitrates per target using priority, enable and threshold.
- Drives one interrupt request per target (e.g. machine external interrupt of each hart).
- Sits between peripheral interrupt lines and CPU cores; software claims and completes interrupts through memory-mapped registers.

---
 rtl/iob_plic_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_iob_plic_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/iob_plic_ctrl.sv
// Platform-level interrupt controller on the IOb native slave bus: per-source gateways,
// per-target priority/enable/threshold arbitration and claim/complete registers.
// Optional macro IOB_PLIC_EDGE_EN adds the EL register and saturating edge counters.
module iob_plic_ctrl #(
    parameter int ADDR_W            = 16,
    parameter int DATA_W            = 32,
    parameter int N_SOURCES         = 8,
    parameter int N_TARGETS         = 2,
    parameter int PRIORITIES        = 8,
    parameter int MAX_PENDING_COUNT = 8,
    parameter int HAS_THRESHOLD     = 1,
    parameter int HAS_CONFIG_REG    = 1
) (
    input  logic                  clk_i,
    input  logic                  cke_i,
    input  logic                  arst_i,
    input  logic                  iob_avalid_i,
    input  logic [ADDR_W-1:0]     iob_addr_i,
    input  logic [DATA_W-1:0]     iob_wdata_i,
    input  logic [DATA_W/8-1:0]   iob_wstrb_i,
    output logic                  iob_rvalid_o,
    output logic [DATA_W-1:0]     iob_rdata_o,
    output logic                  iob_ready_o,
    input  logic [N_SOURCES-1:0]  src,
    output logic [N_TARGETS-1:0]  irq
);
    localparam int PW = (PRIORITIES > 1) ? $clog2(PRIORITIES) : 1;
    localparam int IW = $clog2(N_SOURCES + 1);
    localparam logic [31:0] CONFIG_VAL = 32'((N_SOURCES % 256)
                                           + (N_TARGETS % 16) * 256
                                           + (PRIORITIES % 256) * 4096
                                           + ((HAS_THRESHOLD != 0) ? 32'h0010_0000 : 32'h0));

    genvar gi;

    if (DATA_W != 32 || N_SOURCES < 1 || N_SOURCES > 31 || N_TARGETS < 1 || N_TARGETS > 8
        || MAX_PENDING_COUNT < 1) begin : g_bad_params
        $error("iob_plic_ctrl: unsupported parameter combination");
    end

    logic [ADDR_W-1:0]    word_addr;
    logic                 rd_req;
    logic                 wr_req;
    logic [N_SOURCES-1:0] prio_sel;
    logic [N_TARGETS-1:0] enable_sel;
    logic [N_TARGETS-1:0] thresh_sel;
    logic [N_TARGETS-1:0] claim_sel;

    logic [PW-1:0]        prio_reg   [N_SOURCES];
    logic [N_SOURCES-1:0] enable_reg [N_TARGETS];
    logic [PW-1:0]        thresh_reg [N_TARGETS];
    logic [N_SOURCES-1:0] pending_reg;
    logic [N_SOURCES-1:0] in_service_reg;
    logic [N_TARGETS-1:0] irq_reg;
    logic                 rvalid_reg;
    logic [DATA_W-1:0]    rdata_reg;

    logic [N_SOURCES-1:0] el;
    logic [N_SOURCES-1:0] gw_req;
    logic [N_SOURCES-1:0] claim_vec;
    logic [N_SOURCES-1:0] complete_vec;
    logic [IW-1:0]        win_id [N_TARGETS];
    logic [DATA_W-1:0]    rd_val;

    assign word_addr = iob_addr_i & ~ADDR_W'(3);
    assign rd_req    = cke_i & iob_avalid_i & (iob_wstrb_i == '0);
    assign wr_req    = cke_i & iob_avalid_i & (iob_wstrb_i != '0);

    for (gi = 0; gi < N_SOURCES; gi++) begin : g_src_dec
        assign prio_sel[gi] = (word_addr == ADDR_W'(32'h100 + 4 * gi));
    end

    for (gi = 0; gi < N_TARGETS; gi++) begin : g_tgt_dec
        assign enable_sel[gi] = (word_addr == ADDR_W'(32'h200 + 4 * gi));
        assign thresh_sel[gi] = (word_addr == ADDR_W'(32'h300 + 8 * gi));
        assign claim_sel[gi]  = (word_addr == ADDR_W'(32'h304 + 8 * gi));
    end

    // Starting the search at the threshold folds "priority > threshold" into the
    // strict compare; strict > also keeps the lowest ID on priority ties.
    for (gi = 0; gi < N_TARGETS; gi++) begin : g_arb
        logic [PW-1:0] best_prio;
        logic [IW-1:0] best_id;
        always_comb begin
            best_prio = thresh_reg[gi];
            best_id   = '0;
            for (int i = 0; i < N_SOURCES; i++) begin
                if (pending_reg[i] && enable_reg[gi][i] && (prio_reg[i] > best_prio)) begin
                    best_prio = prio_reg[i];
                    best_id   = IW'(i + 1);
                end
            end
        end
        assign win_id[gi] = best_id;
    end

    always_comb begin
        claim_vec    = '0;
        complete_vec = '0;
        for (int t = 0; t < N_TARGETS; t++) begin
            for (int i = 0; i < N_SOURCES; i++) begin
                if (rd_req && claim_sel[t] && (win_id[t] == IW'(i + 1)))
                    claim_vec[i] = 1'b1;
                if (wr_req && claim_sel[t] && (iob_wdata_i == DATA_W'(i + 1)))
                    complete_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        if (HAS_CONFIG_REG != 0 && word_addr == ADDR_W'(0))
            rd_val = DATA_W'(CONFIG_VAL);
        if (word_addr == ADDR_W'(4))
            rd_val = DATA_W'(el);
        if (word_addr == ADDR_W'(8))
            rd_val = DATA_W'(pending_reg);
        for (int i = 0; i < N_SOURCES; i++) begin
            if (prio_sel[i])
                rd_val = DATA_W'(prio_reg[i]);
        end
        for (int t = 0; t < N_TARGETS; t++) begin
            if (enable_sel[t])
                rd_val = DATA_W'(enable_reg[t]);
            if (thresh_sel[t])
                rd_val = DATA_W'(thresh_reg[t]);
            if (claim_sel[t])
                rd_val = DATA_W'(win_id[t]);
        end
    end

`ifdef IOB_PLIC_EDGE_EN
    localparam int CW = $clog2(MAX_PENDING_COUNT + 1);

    logic [N_SOURCES-1:0] el_reg;
    logic [N_SOURCES-1:0] src_prev_reg;
    logic [N_SOURCES-1:0] rise;
    logic [CW-1:0]        cnt_reg [N_SOURCES];

    assign el   = el_reg;
    assign rise = el_reg & src & ~src_prev_reg;

    for (gi = 0; gi < N_SOURCES; gi++) begin : g_gw
        assign gw_req[gi] = el_reg[gi] ? (cnt_reg[gi] != '0) : src[gi];
    end

    // A rise and a claim in the same cycle cancel, so the count nets zero.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            el_reg       <= '0;
            src_prev_reg <= '0;
            for (int i = 0; i < N_SOURCES; i++)
                cnt_reg[i] <= '0;
        end else if (cke_i) begin
            src_prev_reg <= src;
            if (wr_req && word_addr == ADDR_W'(4))
                el_reg <= iob_wdata_i[N_SOURCES-1:0];
            for (int i = 0; i < N_SOURCES; i++) begin
                if (rise[i] && !claim_vec[i]) begin
                    if (cnt_reg[i] != CW'(MAX_PENDING_COUNT))
                        cnt_reg[i] <= cnt_reg[i] + CW'(1);
                end else if (!rise[i] && claim_vec[i] && cnt_reg[i] != '0) begin
                    cnt_reg[i] <= cnt_reg[i] - CW'(1);
                end
            end
        end
    end
`else
    assign el     = '0;
    assign gw_req = src;
`endif

    // Claim clears pending in the same edge a gateway would set it, so the claim wins.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            pending_reg    <= '0;
            in_service_reg <= '0;
            irq_reg        <= '0;
            rvalid_reg     <= 1'b0;
            rdata_reg      <= '0;
            for (int i = 0; i < N_SOURCES; i++)
                prio_reg[i] <= '0;
            for (int t = 0; t < N_TARGETS; t++) begin
                enable_reg[t] <= '0;
                thresh_reg[t] <= '0;
            end
        end else if (cke_i) begin
            rvalid_reg <= rd_req;
            if (rd_req)
                rdata_reg <= rd_val;
            pending_reg    <= (pending_reg | (gw_req & ~in_service_reg)) & ~claim_vec;
            in_service_reg <= (in_service_reg | claim_vec) & ~complete_vec;
            for (int t = 0; t < N_TARGETS; t++)
                irq_reg[t] <= (win_id[t] != '0);
            if (wr_req) begin
                for (int i = 0; i < N_SOURCES; i++) begin
                    if (prio_sel[i])
                        prio_reg[i] <= iob_wdata_i[PW-1:0];
                end
                for (int t = 0; t < N_TARGETS; t++) begin
                    if (enable_sel[t])
                        enable_reg[t] <= iob_wdata_i[N_SOURCES-1:0];
                    if (HAS_THRESHOLD != 0 && thresh_sel[t])
                        thresh_reg[t] <= iob_wdata_i[PW-1:0];
                end
            end
        end
    end

    assign iob_ready_o  = 1'b1;
    assign iob_rvalid_o = rvalid_reg;
    assign iob_rdata_o  = rdata_reg;
    assign irq          = irq_reg;

endmodule

// File: tb/tb_iob_plic_ctrl.sv
// Directed bench for iob_plic_ctrl: register access, arbitration, threshold,
// level re-pend, edge counting (IOB_PLIC_EDGE_EN) and asynchronous reset.
module tb_iob_plic_ctrl;
    logic        clk = 1'b0;
    logic        cke;
    logic        arst;
    logic        avalid;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic [7:0]  src;
    logic [1:0]  irq;

    int n_vec = 0;
    int n_err = 0;
    logic [31:0] rd;

    iob_plic_ctrl dut (
        .clk_i        (clk),
        .cke_i        (cke),
        .arst_i       (arst),
        .iob_avalid_i (avalid),
        .iob_addr_i   (addr),
        .iob_wdata_i  (wdata),
        .iob_wstrb_i  (wstrb),
        .iob_rvalid_o (rvalid),
        .iob_rdata_o  (rdata),
        .iob_ready_o  (ready),
        .src          (src),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    task automatic cycles(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        avalid = 1'b1; addr = a; wdata = d; wstrb = 4'hf;
        @(negedge clk);
        avalid = 1'b0; wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        avalid = 1'b1; addr = a; wstrb = 4'h0;
        @(negedge clk);
        avalid = 1'b0;
        n = 0;
        while (!rvalid && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!rvalid) check("rvalid_timeout", 32'(rvalid), 32'h1);
        d = rdata;
    endtask

    initial begin
        cke = 1'b1; arst = 1'b1; avalid = 1'b0; addr = '0; wdata = '0; wstrb = '0; src = '0;
        cycles(3);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("ready", 32'(ready), 32'h1);
        arst = 1'b0;
        cycles(1);

        // CONFIG: 8 sources, 2 targets, 8 priorities, threshold bit 20 set
        bus_read(16'h000, rd); check("config", rd, 32'h0010_8208);
        @(negedge clk);
        check("rvalid_one_cycle", 32'(rvalid), 32'h0);
        check("rdata_hold", rdata, 32'h0010_8208);
        bus_read(16'h004, rd); check("el_rst", rd, 32'h0);
        bus_read(16'h008, rd); check("pending_rst", rd, 32'h0);
        bus_read(16'h100, rd); check("prio0_rst", rd, 32'h0);
        bus_read(16'h204, rd); check("enable1_rst", rd, 32'h0);
        bus_read(16'h300, rd); check("thresh0_rst", rd, 32'h0);
        bus_read(16'h304, rd); check("claim0_rst", rd, 32'h0);
        bus_read(16'h050, rd); check("unmapped", rd, 32'h0);

        // Single source through target 0
        bus_write(16'h108, 32'hff);
        bus_read(16'h108, rd); check("prio2_mask", rd, 32'h7);
        bus_write(16'h108, 32'h5);
        bus_write(16'h200, 32'h04);
        bus_write(16'h300, 32'h0);
        @(negedge clk); src[2] = 1'b1;
        cycles(2);
        check("irq_src2", 32'(irq), 32'h1);
        src[2] = 1'b0;
        bus_read(16'h008, rd); check("pending_src2", rd, 32'h04);
        bus_read(16'h304, rd); check("claim_src2", rd, 32'h3);
        bus_read(16'h008, rd); check("pending_after_claim", rd, 32'h0);
        check("irq_after_claim", 32'(irq), 32'h0);
        bus_write(16'h304, 32'h3);
        cycles(2);
        check("irq_after_complete", 32'(irq), 32'h0);

        // Priority ordering on target 1, tie goes to lowest ID
        bus_write(16'h200, 32'h0);
        bus_write(16'h104, 32'h3);
        bus_write(16'h114, 32'h3);
        bus_write(16'h118, 32'h6);
        bus_write(16'h204, 32'h62);
        @(negedge clk); src = 8'h62;
        cycles(2);
        src = 8'h00;
        cycles(2);
        check("irq_t1", 32'(irq), 32'h2);
        bus_read(16'h30c, rd); check("claim_t1_a", rd, 32'h7);
        bus_read(16'h30c, rd); check("claim_t1_b", rd, 32'h2);
        bus_read(16'h30c, rd); check("claim_t1_c", rd, 32'h6);
        bus_read(16'h30c, rd); check("claim_t1_d", rd, 32'h0);
        check("irq_t1_done", 32'(irq), 32'h0);
        bus_write(16'h30c, 32'h7);
        bus_write(16'h30c, 32'h2);
        bus_write(16'h30c, 32'h6);

        // Threshold masking
        bus_write(16'h200, 32'h04);
        bus_write(16'h300, 32'h5);
        @(negedge clk); src[2] = 1'b1;
        @(negedge clk); src[2] = 1'b0;
        cycles(2);
        bus_read(16'h008, rd); check("pending_thr", rd, 32'h04);
        check("irq_thr5", 32'(irq), 32'h0);
        bus_read(16'h304, rd); check("claim_thr5", rd, 32'h0);
        bus_write(16'h300, 32'h4);
        cycles(2);
        check("irq_thr4", 32'(irq), 32'h1);
        bus_read(16'h300, rd); check("thresh0_rb", rd, 32'h4);
        bus_read(16'h304, rd); check("claim_thr4", rd, 32'h3);
        bus_write(16'h304, 32'h3);
        bus_write(16'h300, 32'h0);

        // Level source held high: no re-pend while in service
        @(negedge clk); src[2] = 1'b1;
        cycles(2);
        check("irq_level", 32'(irq), 32'h1);
        bus_read(16'h304, rd); check("claim_level", rd, 32'h3);
        cycles(3);
        bus_read(16'h008, rd); check("no_repend", rd, 32'h0);
        bus_write(16'h304, 32'h9);
        bus_write(16'h304, 32'h0);
        cycles(2);
        bus_read(16'h008, rd); check("bad_complete_ignored", rd, 32'h0);
        bus_write(16'h304, 32'h3);
        @(negedge clk);
        bus_read(16'h008, rd); check("repend", rd, 32'h04);
        check("irq_repend", 32'(irq), 32'h1);
        src[2] = 1'b0;
        bus_read(16'h304, rd); check("claim_repend", rd, 32'h3);
        bus_write(16'h304, 32'h3);

`ifdef IOB_PLIC_EDGE_EN
        // Edge source: ten pulses saturate the counter at eight
        bus_write(16'h004, 32'h01);
        bus_read(16'h004, rd); check("el_rb", rd, 32'h01);
        bus_write(16'h100, 32'h1);
        bus_write(16'h200, 32'h01);
        for (int p = 0; p < 10; p++) begin
            @(negedge clk); src[0] = 1'b1;
            @(negedge clk); src[0] = 1'b0;
        end
        cycles(2);
        for (int c = 0; c < 8; c++) begin
            bus_read(16'h304, rd); check($sformatf("edge_claim_%0d", c), rd, 32'h1);
            bus_write(16'h304, 32'h1);
        end
        bus_read(16'h304, rd); check("edge_claim_empty", rd, 32'h0);
        bus_write(16'h200, 32'h04);
`else
        bus_write(16'h004, 32'h01);
        bus_read(16'h004, rd); check("el_fixed", rd, 32'h0);
`endif

        // Asynchronous reset mid-operation
        @(negedge clk); src[2] = 1'b1;
        @(negedge clk); src[2] = 1'b0;
        cycles(2);
        check("irq_pre_rst", 32'(irq), 32'h1);
        @(posedge clk);
        #2 arst = 1'b1;
        #1 check("irq_async_rst", 32'(irq), 32'h0);
        cycles(2);
        arst = 1'b0;
        bus_read(16'h008, rd); check("pending_post_rst", rd, 32'h0);
        bus_read(16'h108, rd); check("prio2_post_rst", rd, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
